// File: rtl/vec_check_if.sv
// Vector-memory and DUT-side bus for the test-vector sequencer.
// The sequencer holds the master side; memory and DUT sit on the slave side.
interface vec_check_if #(
    parameter int S_W = 2,
    parameter int X_W = 1,
    parameter int AW  = 4
);
    logic [AW-1:0]      vec_addr;
    logic [S_W+X_W-1:0] vec_data;
    logic [S_W-1:0]     dut_s;
    logic [X_W-1:0]     dut_x;

    modport master (
        output vec_addr,
        output dut_s,
        input  vec_data,
        input  dut_x
    );

    modport slave (
        input  vec_addr,
        input  dut_s,
        output vec_data,
        output dut_x
    );
endinterface

// File: rtl/vec_check_seq.sv
// On-board test-vector sequencer/checker: fetch {s, exp}, drive s,
// wait SETTLE cycles, compare x, and report first error and error count.
module vec_check_seq #(
    parameter int S_W         = 2,
    parameter int X_W         = 1,
    parameter int AW          = 4,
    parameter int SETTLE      = 5,
    parameter int STOP_ON_ERR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   vec_count,
    vec_check_if.master   bus,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [AW-1:0] err_addr,
    output logic [X_W-1:0] err_exp,
    output logic [X_W-1:0] err_got,
    output logic [7:0]    err_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [AW:0]   MAX_N  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_N  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_I  = AW'(1);
    localparam logic [7:0]    CNT0   = 8'(SETTLE - 1);
    localparam bit            STOP   = (STOP_ON_ERR != 0);

    logic [2:0]     state;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  addr_q;
    logic [AW:0]    n_q;
    logic [AW:0]    n_in;
    logic [7:0]     cnt;
    logic [S_W-1:0] s_q;
    logic [X_W-1:0] exp_q;
    logic           mism;
    logic           last;

    // Counts beyond the memory depth run the whole memory once, never wrap.
    assign n_in = (vec_count > MAX_N) ? MAX_N : vec_count;
    assign mism = (bus.dut_x != exp_q);
    assign last = ({1'b0, idx} == (n_q - ONE_N));

    assign bus.vec_addr = addr_q;
    assign bus.dut_s    = s_q;

    assign busy = (state == FETCH) || (state == LOAD) ||
                  (state == WAIT)  || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == 8'd0);
    assign fail = done && (err_count != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            addr_q    <= '0;
            n_q       <= '0;
            cnt       <= '0;
            s_q       <= '0;
            exp_q     <= '0;
            err_addr  <= '0;
            err_exp   <= '0;
            err_got   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        err_addr  <= '0;
                        err_exp   <= '0;
                        err_got   <= '0;
                        n_q       <= n_in;
                        idx       <= '0;
                        addr_q    <= '0;
                        state     <= (n_in == '0) ? DONE : FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    s_q   <= bus.vec_data[S_W+X_W-1:X_W];
                    exp_q <= bus.vec_data[X_W-1:0];
                    cnt   <= CNT0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 8'd0) state <= CHECK;
                    else             cnt   <= cnt - 8'd1;
                end
                CHECK: begin
                    if (mism) begin
                        if (err_count == 8'd0) begin
                            err_addr <= idx;
                            err_exp  <= exp_q;
                            err_got  <= bus.dut_x;
                        end
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                    if ((mism && STOP) || last) begin
                        state <= DONE;
                    end else begin
                        idx    <= idx + ONE_I;
                        addr_q <= idx + ONE_I;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
